sccb_reg_sequencer: RTL
=======================

SCCB_REG_SEQUENCER -- requirements
Module: sccb_reg_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, meaning the register-table depth (1..256).
REQ-002 SHALL have parameter DEV_WADDR, default 8'h42, meaning the SCCB write ID; the read ID SHALL be DEV_WADDR|1.
REQ-003 SHALL have parameter DELAY_TICKS, default 100, meaning mid_pulse ticks per delay unit.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning the number of re-attempts per entry on readback mismatch.
REQ-005 SHALL have port PCLK, input, 1 bit: the single clock.
REQ-006 SHALL have port PRESETN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port mid_pulse, input, 1 bit: one-PCLK SCCB tick from the clock divider.
REQ-008 SHALL have port go, input, 1 bit: starts a table run, sampled on a tick.
REQ-009 SHALL have ports tbl_idx, output, $clog2(NUM_ENTRIES) bits, and tbl_entry, input, 16 bits {sub_addr, data}, read combinationally.
REQ-010 SHALL have outputs start (1), rw (1), ip_addr (8), sub_addr (8) and data_in (8), and inputs done (1) and data_out (8), forming the CoreSCCB handshake.
REQ-011 SHALL have status outputs busy (1), cfg_done (1), cfg_err (1) and err_idx ($clog2(NUM_ENTRIES)).

Function
REQ-012 SHALL advance state and update all handshake outputs only on PCLK edges where mid_pulse=1.
REQ-013 SHALL implement the states IDLE, FETCH, WRITE, RD_SETUP, READ, CHECK, DELAY, DONE and ERROR.
REQ-014 IDLE: go=1 on a tick SHALL clear tbl_idx, the retry counter, cfg_done and cfg_err, set busy=1, and go to FETCH.
REQ-015 FETCH: an entry of 16'hFFFF, or tbl_idx=NUM_ENTRIES-1 having completed, SHALL end the run in DONE.
REQ-016 FETCH: an entry {8'hFF, n} with n≠8'hFF SHALL go to DELAY for n*DELAY_TICKS ticks (n=0 means zero wait), then advance the index.
REQ-017 FETCH: any other entry SHALL load ip_addr=DEV_WADDR, rw=0, sub_addr and data_in from the entry, and go to WRITE.
REQ-018 WRITE/READ: the block SHALL hold start=1 until a tick with done=1, then drive start=0 on that tick and leave the state.
REQ-019 Each transaction SHALL present start=0 for at least one tick before being asserted.
REQ-020 WRITE completion SHALL go to RD_SETUP if verification is compiled in, else advance the index and return to FETCH.
REQ-021 RD_SETUP SHALL set ip_addr=DEV_WADDR|1, rw=1, keep sub_addr, then go to READ; READ completion SHALL go to CHECK.
REQ-022 CHECK: data_out==data_in SHALL advance the index, clear retries and go to FETCH.
REQ-023 CHECK: a mismatch with retries<MAX_RETRY SHALL increment retries and go to FETCH for the same index.
REQ-024 CHECK: a mismatch with retries=MAX_RETRY SHALL latch err_idx=tbl_idx, set cfg_err=1 and go to ERROR.
REQ-025 The index increment SHALL NOT wrap; the final entry terminates per REQ-015.
REQ-026 DONE/ERROR SHALL set busy=0, hold cfg_done or cfg_err, and return to IDLE-equivalent handling on the next go (go restarts the run).
REQ-027 go asserted while busy=1 SHALL be ignored.

Reset
REQ-028 PRESETN=0 SHALL immediately force IDLE, start=0, rw=0, ip_addr=0, sub_addr=0, data_in=0, tbl_idx=0, busy=0, cfg_done=0, cfg_err=0, err_idx=0 and retries=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no resumption; a new go restarts from index 0.

Configuration
REQ-030 The macro SCCB_VERIFY_EN, when defined, SHALL compile in RD_SETUP/READ/CHECK, the retry counter and the mismatch error path.
REQ-031 When SCCB_VERIFY_EN is undefined, the block SHALL perform writes only, cfg_err SHALL be tied 0, err_idx SHALL be tied 0, and data_out SHALL be unused.

Structure
REQ-032 The state encoding, the END marker 16'hFFFF and the DELAY marker 8'hFF SHALL live in shared package sccb_pkg.
REQ-033 The delay/tick counter SHALL be a sub-module sccb_tick_timer (load, count on mid_pulse, expire flag).

Verification
REQ-034 A 3-entry table {12,80},{11,01},{FFFF} with a done-responding model SHALL give two writes (ip_addr 42) and cfg_done=1, busy=0.
REQ-035 Entry {FF,02} with DELAY_TICKS=100 SHALL produce exactly 200 ticks between the adjacent transactions.
REQ-036 With SCCB_VERIFY_EN and a model returning 0x00 for {3A,04} and MAX_RETRY=3 SHALL give 4 writes, then cfg_err=1 and err_idx=that index.
REQ-037 With SCCB_VERIFY_EN and a model mismatching once then matching SHALL give 2 write/read pairs, no error and cfg_done=1.
REQ-038 PRESETN pulsed low during WRITE with start=1 SHALL drop start immediately, and a subsequent go SHALL restart at tbl_idx=0.
REQ-039 A full NUM_ENTRIES table with no END marker SHALL end in DONE after the last entry with no tbl_idx wrap.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg -- shared state encoding and table markers for the SCCB register
// sequencer (sccb_reg_sequencer) and its tick timer.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_RD_SETUP,
        ST_READ,
        ST_CHECK,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } sccb_state_t;

    // A table entry equal to this ends the run.
    localparam logic [15:0] SCCB_END_MARKER   = 16'hFFFF;
    // A table entry whose upper byte equals this is a delay of n units.
    localparam logic [7:0]  SCCB_DELAY_MARKER = 8'hFF;

    function automatic logic sccb_is_delay(input logic [15:0] entry);
        return (entry[15:8] == SCCB_DELAY_MARKER) && (entry != SCCB_END_MARKER);
    endfunction

endpackage

// File: rtl/sccb_tick_timer.sv
// sccb_tick_timer -- loadable down-counter stepped by the SCCB tick; expire is
// high while the count sits at zero.
module sccb_tick_timer #(
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             mid_pulse,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Load has priority; otherwise count down one per tick, stopping at zero.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (mid_pulse && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/sccb_reg_sequencer.sv
// sccb_reg_sequencer -- walks a {sub_addr, data} register table and issues
// SCCB writes through the CoreSCCB start/done handshake, with inline delay
// entries. Define SCCB_VERIFY_EN to add read-back verification with up to
// MAX_RETRY re-attempts per entry and a mismatch error path.
//
// state    | meaning
// IDLE     | waiting for go
// FETCH    | decode tbl_entry at tbl_idx
// WRITE    | write transaction in flight
// RD_SETUP | switch to read ID for read-back
// READ     | read transaction in flight
// CHECK    | compare read-back with written data
// DELAY    | waiting n*DELAY_TICKS ticks
// DONE     | table finished, cfg_done held
// ERROR    | retries exhausted, cfg_err held
module sccb_reg_sequencer
    import sccb_pkg::*;
#(
    parameter int         NUM_ENTRIES = 64,
    parameter logic [7:0] DEV_WADDR   = 8'h42,
    parameter int         DELAY_TICKS = 100,
    parameter int         MAX_RETRY   = 3,
    localparam int        IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    input  logic             mid_pulse,
    input  logic             go,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_entry,
    output logic             start,
    output logic             rw,
    output logic [7:0]       ip_addr,
    output logic [7:0]       sub_addr,
    output logic [7:0]       data_in,
    input  logic             done,
    input  logic [7:0]       data_out,
    output logic             busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_idx
);

    localparam int CNT_W = (DELAY_TICKS > 0) ? $clog2(255 * DELAY_TICKS + 1) : 1;

    sccb_state_t      state, nxt_state;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_start, nxt_rw, nxt_busy, nxt_done;
    logic [7:0]       nxt_ip, nxt_sub, nxt_din;
    logic             adv, last_entry;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val;

`ifdef SCCB_VERIFY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTY_W-1:0] retries, nxt_retries;
    logic             cfg_err_q, nxt_err;
    logic [IDX_W-1:0] err_idx_q, nxt_err_idx;

    assign cfg_err = cfg_err_q;
    assign err_idx = err_idx_q;
`else
    logic unused_data_out;

    assign unused_data_out = ^data_out;
    assign cfg_err         = 1'b0;
    assign err_idx         = '0;
`endif

    assign last_entry = (tbl_idx == IDX_W'(NUM_ENTRIES - 1));
    assign tmr_val    = CNT_W'(32'(tbl_entry[7:0]) * DELAY_TICKS);

    sccb_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .mid_pulse (mid_pulse),
        .load      (tmr_load & mid_pulse),
        .load_val  (tmr_val),
        .expire    (tmr_expire)
    );

    // Register state and all handshake/status outputs, only on SCCB ticks.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= ST_IDLE;
            tbl_idx   <= '0;
            start     <= 1'b0;
            rw        <= 1'b0;
            ip_addr   <= '0;
            sub_addr  <= '0;
            data_in   <= '0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
`ifdef SCCB_VERIFY_EN
            retries   <= '0;
            cfg_err_q <= 1'b0;
            err_idx_q <= '0;
`endif
        end else if (mid_pulse) begin
            state     <= nxt_state;
            tbl_idx   <= nxt_idx;
            start     <= nxt_start;
            rw        <= nxt_rw;
            ip_addr   <= nxt_ip;
            sub_addr  <= nxt_sub;
            data_in   <= nxt_din;
            busy      <= nxt_busy;
            cfg_done  <= nxt_done;
`ifdef SCCB_VERIFY_EN
            retries   <= nxt_retries;
            cfg_err_q <= nxt_err;
            err_idx_q <= nxt_err_idx;
`endif
        end
    end

    // Next-state and next-output decode; adv means the current entry is finished.
    always_comb begin
        nxt_state   = state;
        nxt_idx     = tbl_idx;
        nxt_start   = start;
        nxt_rw      = rw;
        nxt_ip      = ip_addr;
        nxt_sub     = sub_addr;
        nxt_din     = data_in;
        nxt_busy    = busy;
        nxt_done    = cfg_done;
        tmr_load    = 1'b0;
        adv         = 1'b0;
`ifdef SCCB_VERIFY_EN
        nxt_retries = retries;
        nxt_err     = cfg_err_q;
        nxt_err_idx = err_idx_q;
`endif
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go) begin
                    nxt_idx   = '0;
                    nxt_done  = 1'b0;
                    nxt_busy  = 1'b1;
                    nxt_state = ST_FETCH;
`ifdef SCCB_VERIFY_EN
                    nxt_retries = '0;
                    nxt_err     = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                if (tbl_entry == SCCB_END_MARKER) begin
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                    nxt_state = ST_DONE;
                end else if (sccb_is_delay(tbl_entry)) begin
                    tmr_load  = 1'b1;
                    nxt_state = ST_DELAY;
                end else begin
                    nxt_ip    = DEV_WADDR;
                    nxt_rw    = 1'b0;
                    nxt_sub   = tbl_entry[15:8];
                    nxt_din   = tbl_entry[7:0];
                    nxt_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // start rises one tick after entry, so it was low for at least a tick
                if (!start) begin
                    nxt_start = 1'b1;
                end else if (done) begin
                    nxt_start = 1'b0;
`ifdef SCCB_VERIFY_EN
                    nxt_state = ST_RD_SETUP;
`else
                    adv       = 1'b1;
`endif
                end
            end
`ifdef SCCB_VERIFY_EN
            ST_RD_SETUP: begin
                nxt_ip    = DEV_WADDR | 8'h01;
                nxt_rw    = 1'b1;
                nxt_state = ST_READ;
            end
            ST_READ: begin
                if (!start) begin
                    nxt_start = 1'b1;
                end else if (done) begin
                    nxt_start = 1'b0;
                    nxt_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (data_out == data_in) begin
                    adv = 1'b1;
                end else if (retries < RTY_W'(MAX_RETRY)) begin
                    nxt_retries = retries + RTY_W'(1);
                    nxt_state   = ST_FETCH;
                end else begin
                    nxt_err_idx = tbl_idx;
                    nxt_err     = 1'b1;
                    nxt_busy    = 1'b0;
                    nxt_state   = ST_ERROR;
                end
            end
`endif
            ST_DELAY: begin
                if (tmr_expire) begin
                    adv = 1'b1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // The index never wraps: finishing the last slot ends the run.
        if (adv) begin
`ifdef SCCB_VERIFY_EN
            nxt_retries = '0;
`endif
            if (last_entry) begin
                nxt_busy  = 1'b0;
                nxt_done  = 1'b1;
                nxt_state = ST_DONE;
            end else begin
                nxt_idx   = tbl_idx + IDX_W'(1);
                nxt_state = ST_FETCH;
            end
        end
    end

endmodule
